// File: rtl/ccip_shim_pkg.sv
// Shared types and helpers for the CCI-P shim blocks.
//   t_ccip_c0_ReqMemHdr : C0 read request header (cl_len = lines-1)
//   t_c0_rdlim_state    : issue decision of ccip_c0_rd_limiter
//   c0_cl_lines()       : cache lines requested by a header's cl_len
package ccip_shim_pkg;

  typedef logic [1:0] t_ccip_clLen;

  typedef struct packed {
    logic [1:0]  vc_sel;
    logic [1:0]  rsvd1;
    t_ccip_clLen cl_len;
    logic [3:0]  req_type;
    logic [5:0]  rsvd0;
    logic [41:0] address;
    logic [15:0] mdata;
  } t_ccip_c0_ReqMemHdr;

  localparam int unsigned CCIP_C0_HDR_W = $bits(t_ccip_c0_ReqMemHdr);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD_AF,
    HOLD_CR
  } t_c0_rdlim_state;

  // cl_len 0/1/3 -> 1/2/4 lines; the illegal encoding 2 simply costs 3.
  function automatic logic [2:0] c0_cl_lines(input t_ccip_clLen cl_len);
    return {1'b0, cl_len} + 3'd1;
  endfunction

endpackage

// File: rtl/ccip_c0_rd_limiter_if.sv
// C0 TX request path through the read limiter.
//   in_valid/in_hdr/in_ready : AFU-side request handshake
//   c0TxAlmFull              : almost-full from the shim's C0 TX
//   out_valid/out_hdr        : issue strobe and header toward the shim
// slave  : the limiter's view
// master : the surrounding AFU/shim view
interface ccip_c0_rd_limiter_if;
  import ccip_shim_pkg::*;

  logic               in_valid;
  t_ccip_c0_ReqMemHdr in_hdr;
  logic               in_ready;
  logic               c0TxAlmFull;
  logic               out_valid;
  t_ccip_c0_ReqMemHdr out_hdr;

  modport slave (
    input  in_valid, in_hdr, c0TxAlmFull,
    output in_ready, out_valid, out_hdr
  );

  modport master (
    output in_valid, in_hdr, c0TxAlmFull,
    input  in_ready, out_valid, out_hdr
  );

endinterface

// File: rtl/ccip_hdr_fifo.sv
// Generic synchronous FIFO (first-word fall-through read data).
//   clk, rst_n      : clock, asynchronous active-low reset
//   wr_en, wr_data  : write; ignored while full
//   rd_en           : pop the head entry; ignored while empty
//   rd_data         : current head entry (valid when !empty)
//   full, empty     : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module ccip_hdr_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ccip_c0_rd_limiter.sv
// C0 read-request flow-control stage between the AFU and ccip_async_shim.
// Buffers request headers and issues one per cycle toward the shim only
// while the channel is not almost-full and the outstanding-line budget
// (MAX_OUTSTANDING) allows the head request; returned lines free budget.
//   afu_clk, afu_softreset_n : clock, asynchronous active-low reset
//   io (slave)               : in_valid/in_hdr/in_ready, c0TxAlmFull,
//                              out_valid/out_hdr
//   rx_rd_line               : one pulse per returned read line
//   outstanding              : lines requested but not yet returned
//   err_underflow            : sticky, a line returned with none pending
module ccip_c0_rd_limiter import ccip_shim_pkg::*; #(
  parameter int unsigned MAX_OUTSTANDING = 256,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                                 afu_clk,
  input  logic                                 afu_softreset_n,
  ccip_c0_rd_limiter_if.slave                  io,
  input  logic                                 rx_rd_line,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 err_underflow
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  t_c0_rdlim_state    state;
  t_c0_rdlim_state    state_q;
  t_ccip_c0_ReqMemHdr head_hdr;
  logic               full;
  logic               empty;
  logic               ready_en;
  logic               issue;
  logic [2:0]         lines;
  logic               credit_ok;
  logic [OW:0]        sum;
  logic [OW-1:0]      outstanding_nxt;
  logic               underflow_set;

  // Holds in_ready low through reset and releases it on the first edge after.
  always_ff @(posedge afu_clk or negedge afu_softreset_n) begin
    if (!afu_softreset_n) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  assign io.in_ready = ready_en && !full;

  ccip_hdr_fifo #(
    .WIDTH (CCIP_C0_HDR_W),
    .DEPTH (FIFO_DEPTH)
  ) hdr_fifo (
    .clk     (afu_clk),
    .rst_n   (afu_softreset_n),
    .wr_en   (io.in_valid && io.in_ready),
    .wr_data (io.in_hdr),
    .rd_en   (issue),
    .rd_data (head_hdr),
    .full    (full),
    .empty   (empty)
  );

  assign lines = c0_cl_lines(head_hdr.cl_len);

  // One extra bit so outstanding + lines cannot wrap before the compare.
  assign credit_ok = ({1'b0, outstanding} + (OW+1)'(lines)) <= (OW+1)'(MAX_OUTSTANDING);

  // Decision is re-derived every cycle from the current inputs; almost-full
  // outranks a credit shortage.
  always_comb begin
    state = IDLE;
    issue = 1'b0;
    if (empty) begin
      state = IDLE;
    end else if (io.c0TxAlmFull) begin
      state = HOLD_AF;
    end else if (!credit_ok) begin
      state = HOLD_CR;
    end else begin
      state = ISSUE;
      issue = 1'b1;
    end
  end

  assign sum = {1'b0, outstanding} + (issue ? (OW+1)'(lines) : '0);

  always_comb begin
    outstanding_nxt = OW'(sum);
    underflow_set   = 1'b0;
    if (rx_rd_line) begin
      if (sum == '0) begin
        outstanding_nxt = '0;
        underflow_set   = 1'b1;
      end else begin
        outstanding_nxt = OW'(sum - 1'b1);
      end
    end
  end

  always_ff @(posedge afu_clk or negedge afu_softreset_n) begin
    if (!afu_softreset_n) begin
      state_q       <= IDLE;
      outstanding   <= '0;
      err_underflow <= 1'b0;
      io.out_valid  <= 1'b0;
      io.out_hdr    <= '0;
    end else begin
      state_q       <= state;
      outstanding   <= outstanding_nxt;
      err_underflow <= err_underflow || underflow_set;
      io.out_valid  <= issue;
      if (issue) begin
        io.out_hdr <= head_hdr;
      end
    end
  end

  a_valid_tracks_issue: assert property (
    @(posedge afu_clk) disable iff (!afu_softreset_n)
    io.out_valid |-> (state_q == ISSUE)
  );

endmodule

// File: tb/tb_ccip_c0_rd_limiter.sv
module tb_ccip_c0_rd_limiter;
  import ccip_shim_pkg::*;

  localparam int MAXO  = 8;
  localparam int DEPTH = 4;
  localparam int OW    = $clog2(MAXO + 1);

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          rx    = 1'b0;
  logic [OW-1:0] outstanding;
  logic          err_underflow;

  ccip_c0_rd_limiter_if bus ();

  ccip_c0_rd_limiter #(
    .MAX_OUTSTANDING (MAXO),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .afu_clk         (clk),
    .afu_softreset_n (rst_n),
    .io              (bus),
    .rx_rd_line      (rx),
    .outstanding     (outstanding),
    .err_underflow   (err_underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending requests as a queue, budget as a plain integer.
  t_ccip_c0_ReqMemHdr m_q[$];
  t_ccip_c0_ReqMemHdr exp_q[$];
  int                 m_outs = 0;
  bit                 m_err  = 0;
  bit                 m_rdy  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      exp_q.delete();
      m_outs = 0;
      m_err  = 0;
      m_rdy  = 0;
    end else begin
      bit iss;
      bit acc;
      int cost;
      iss  = 0;
      cost = 0;
      if (m_q.size() > 0 && !bus.c0TxAlmFull) begin
        cost = int'(m_q[0].cl_len) + 1;
        if (m_outs + cost <= MAXO) iss = 1;
      end
      acc = bus.in_valid && m_rdy && (m_q.size() < DEPTH);
      if (iss) exp_q.push_back(m_q.pop_front());
      if (acc) m_q.push_back(bus.in_hdr);
      if (iss) m_outs += cost;
      if (rx) begin
        if (m_outs > 0) m_outs--;
        else m_err = 1;
      end
      m_rdy = 1;
    end
  end

  // Monitor: compares the DUT against the model every cycle, popping the
  // expected header whenever an issue was predicted.
  t_ccip_c0_ReqMemHdr m_last = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_last = '0;
    end else begin
      chk("in_ready", bus.in_ready, m_rdy && (m_q.size() < DEPTH));
      chk("outstanding", outstanding, m_outs);
      chk("err_underflow", err_underflow, m_err);
      chk("out_valid", bus.out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) m_last = exp_q.pop_front();
      chk("out_hdr", bus.out_hdr, m_last);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic t_ccip_c0_ReqMemHdr mk(input logic [1:0] len, input logic [15:0] tag);
    t_ccip_c0_ReqMemHdr h;
    h          = '0;
    h.cl_len   = len;
    h.req_type = 4'h4;
    h.address  = 42'({$urandom, $urandom});
    h.mdata    = tag;
    return h;
  endfunction

  task automatic send(input t_ccip_c0_ReqMemHdr h);
    int n;
    bit took;
    n    = 0;
    took = 0;
    bus.in_valid = 1'b1;
    bus.in_hdr   = h;
    do begin
      took = bus.in_ready;
      tick();
      n++;
    end while (!took && n < 100);
    bus.in_valid = 1'b0;
    if (!took) chk("send_timeout", took, 1);
  endtask

  task automatic drain(input int n);
    rx = 1'b1;
    tick(n);
    rx = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    t_ccip_c0_ReqMemHdr h;
    t_ccip_c0_ReqMemHdr h3;
    logic [1:0] len;

    bus.in_valid    = 1'b0;
    bus.in_hdr      = '0;
    bus.c0TxAlmFull = 1'b0;
    rx              = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_hdr", bus.out_hdr, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_underflow, 0);
    tick(3);
    rst_n = 1'b1;
    chk("ready_before_edge", bus.in_ready, 0);
    tick();
    chk("ready_after_edge", bus.in_ready, 1);

    // Single 1-line request: issued one cycle after acceptance.
    tick(5);
    h = mk(2'd0, 16'h0001);
    send(h);
    chk("t1_no_early_valid", bus.out_valid, 0);
    tick();
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_hdr", bus.out_hdr, h);
    chk("t1_outstanding", outstanding, 1);
    tick(8);
    drain(1);
    chk("t1_returned", outstanding, 0);

    // Credit limit: three 4-line requests against a budget of 8.
    send(mk(2'd3, 16'h0011));
    send(mk(2'd3, 16'h0012));
    h3 = mk(2'd3, 16'h0013);
    send(h3);
    tick(3);
    chk("t2_full_budget", outstanding, 8);
    chk("t2_third_held", bus.out_valid, 0);
    drain(4);
    chk("t2_after_4th_valid", bus.out_valid, 0);
    chk("t2_after_4th_outs", outstanding, 4);
    tick();
    chk("t2_third_valid", bus.out_valid, 1);
    chk("t2_third_hdr", bus.out_hdr, h3);
    chk("t2_outs_again", outstanding, 8);
    drain(8);
    chk("t2_drained", outstanding, 0);

    // Almost-full: FIFO fills, nothing issues until it drops.
    bus.c0TxAlmFull = 1'b1;
    for (int i = 0; i < 4; i++) send(mk(2'd0, 16'(16'h0020 + i)));
    chk("t3_fifo_full", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    bus.in_hdr   = mk(2'd0, 16'h0024);
    tick(3);
    chk("t3_no_issue", bus.out_valid, 0);
    chk("t3_still_full", bus.in_ready, 0);
    bus.in_valid    = 1'b0;
    bus.c0TxAlmFull = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_burst_issue", bus.out_valid, 1);
    end
    chk("t3_ready_again", bus.in_ready, 1);
    tick();
    chk("t3_burst_end", bus.out_valid, 0);
    send(mk(2'd0, 16'h0025));
    send(mk(2'd0, 16'h0026));
    tick(2);
    chk("t3_outs", outstanding, 6);
    drain(6);

    // Issue and return in the same cycle: net change applied.
    send(mk(2'd3, 16'h0031));
    send(mk(2'd0, 16'h0032));
    tick(2);
    chk("t4_outs5", outstanding, 5);
    send(mk(2'd1, 16'h0033));
    rx = 1'b1;
    tick();
    rx = 1'b0;
    chk("t4_issue", bus.out_valid, 1);
    chk("t4_net", outstanding, 6);
    drain(6);
    chk("t4_drained", outstanding, 0);

    // Underflow is sticky until reset.
    drain(1);
    chk("t5_err_set", err_underflow, 1);
    chk("t5_outs_zero", outstanding, 0);
    tick(3);
    chk("t5_err_sticky", err_underflow, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_err_cleared", err_underflow, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset with buffered requests drops them.
    send(mk(2'd1, 16'h0041));
    tick();
    chk("t6_pre_outs", outstanding, 2);
    bus.c0TxAlmFull = 1'b1;
    for (int i = 0; i < 3; i++) send(mk(2'd0, 16'(16'h0042 + i)));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", bus.out_valid, 0);
    chk("t6_rst_out_hdr", bus.out_hdr, 0);
    chk("t6_rst_outs", outstanding, 0);
    chk("t6_rst_ready", bus.in_ready, 0);
    chk("t6_rst_err", err_underflow, 0);
    bus.c0TxAlmFull = 1'b0;
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_no_stale", bus.out_valid, 0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0:       len = 2'd0;
        1:       len = 2'd1;
        default: len = 2'd3;
      endcase
      bus.in_valid    = ($urandom_range(0, 2) != 0);
      bus.in_hdr      = mk(len, 16'(i));
      bus.c0TxAlmFull = ($urandom_range(0, 3) == 0);
      rx              = (m_outs > 0) && ($urandom_range(0, 1) == 1);
      tick();
    end
    bus.in_valid    = 1'b0;
    bus.c0TxAlmFull = 1'b0;
    rx              = 1'b0;
    tick(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
